gray_step_monitor: RTL
======================

// Module: gray_step_monitor
// PURPOSE
//   Downstream consumer of the free-running 4-bit Gray counter (o_gray). Registers the Gray code,
//   decodes it to binary, checks every transition is a single legal +1 step, tracks lock state,
//   and counts wraps and step errors. Sits between the Gray source and any binary-domain logic.
// PARAMETERS
//   WIDTH      4   Gray/binary code width (>=2)
//   LOCK_CNT   4   consecutive valid steps required to enter LOCKED (1..15)
//   ERR_CW     8   width of saturating error counter
//   WRAP_CW    16  width of rolling wrap counter
// PORTS
//   clk         in   1        system clock, all logic on posedge
//   rst_n       in   1        reset, asynchronous, active-high (rst_n=1 resets)
//   i_gray      in   WIDTH    Gray code from upstream counter, synchronous to clk
//   o_bin       out  WIDTH    decoded binary of registered Gray sample
//   o_bin_vld   out  1        o_bin holds a decoded sample
//   o_locked    out  1        FSM in LOCKED
//   o_step_err  out  1        1-cycle pulse: illegal transition seen while LOCKED
//   o_wrap      out  1        1-cycle pulse: valid step (2^WIDTH-1)->0 while LOCKED
//   o_wrap_cnt  out  WRAP_CW  wraps counted while LOCKED, rolls over
//   o_err_cnt   out  ERR_CW   step errors counted, saturates at all-ones
// BEHAVIOUR
//   - Reset: all outputs 0, internal regs 0, FSM=ACQ. Reset mid-operation aborts immediately.
//   - Pipeline: posedge k captures i_gray into g_q; posedge k+1 registers gray2bin(g_q) into o_bin
//     and updates g_prev/b_prev. Latency i_gray -> o_bin = 2 clocks. All flags align with o_bin.
//   - Decode: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i] for i=W-2..0.
//   - Classification of g_q vs g_prev (binary compare b vs b_prev, mod 2^WIDTH):
//       HOLD  : g_q==g_prev                    (legal, no step)
//       STEP  : b==b_prev+1 mod 2^W (implies 1 bit change)
//       BAD   : anything else (multi-bit change, backward step, skip)
//   - FSM:
//       ACQ    : first sample after reset loads g_prev; o_bin_vld=1 from next clk; -> HUNT.
//       HUNT   : run_cnt++ on STEP; HOLD keeps run_cnt; BAD clears run_cnt (no err pulse/count).
//                run_cnt reaching LOCK_CNT -> LOCKED (o_locked=1 on same edge o_bin shows that step).
//       LOCKED : STEP/HOLD stay. BAD -> o_step_err pulse, o_err_cnt+1 (sat), run_cnt=0, -> HUNT,
//                o_locked=0 on the same edge.
//   - Wrap: STEP with b_prev=2^W-1, b=0 while LOCKED -> o_wrap pulse, o_wrap_cnt+1 (modulo).
//     Wrap step that also completes lock in HUNT is not counted.
//   - BAD exactly at wrap (e.g. 15->1): error only, no wrap pulse.
//   - o_err_cnt at all-ones holds; o_step_err still pulses.
//   - o_bin always tracks decode regardless of FSM state (incl. HUNT, after BAD).
// STRUCTURE
//   - gray_mon_defs.vh: FSM state localparams (ACQ=2'd0, HUNT=2'd1, LOCKED=2'd2), class codes.
//   - Sub-module gray2bin (combinational, parameter WIDTH) instantiated once for decode.
//   - Top holds input reg, prev regs, classifier, FSM, run/err/wrap counters.
// TESTING
//   - Reset held 1 for 1000 ns, i_gray=0 -> all outputs 0; after release o_bin_vld=1 by 3rd clk.
//   - Clean Gray sequence 0,1,3,2,6,... one step/clk -> o_bin=0,1,2,3... 2 clks late, o_locked
//     rises after 4th valid step, o_step_err never 1.
//   - Locked, sequence ...1001(14),1000(15),0000(0) -> o_wrap 1-cycle pulse, o_wrap_cnt=1.
//   - Locked, inject 0010(3)->0111(5) -> o_step_err pulse, o_err_cnt=1, o_locked=0, relock after 4 steps.
//   - Steps interleaved with 3-cycle holds -> stays LOCKED, no errors; backward step 5->4 -> BAD.
//   - 255+ injected errors -> o_err_cnt saturates 8'hFF; assert rst_n mid-stream -> all outputs 0 async.

Source files
------------

// File: rtl/gray_step_monitor_pkg.sv
// Shared types for the Gray step monitor: FSM states and transition classes.
package gray_step_monitor_pkg;

    // Width of the consecutive-step counter; LOCK_CNT is limited to 1..15.
    localparam int unsigned RunW = 4;

    typedef enum logic [1:0] {
        StAcq    = 2'd0,
        StHunt   = 2'd1,
        StLocked = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ClsHold = 2'd0,
        ClsStep = 2'd1,
        ClsBad  = 2'd2
    } step_cls_e;

endpackage

// File: rtl/gray_step_monitor_gray2bin.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at or above it.
module gray_step_monitor_gray2bin #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Running XOR from the MSB down.
    always_comb begin
        logic acc;
        acc = 1'b0;
        bin = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            acc    = acc ^ gray[i];
            bin[i] = acc;
        end
    end

endmodule

// File: rtl/gray_step_monitor.sv
// Registers an upstream Gray count, decodes it, checks each transition is a legal +1 step,
// tracks lock, and counts wraps (while locked) and step errors (saturating).
module gray_step_monitor
    import gray_step_monitor_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned ERR_CW   = 8,
    parameter int unsigned WRAP_CW  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   i_gray,
    output logic [WIDTH-1:0]   o_bin,
    output logic               o_bin_vld,
    output logic               o_locked,
    output logic               o_step_err,
    output logic               o_wrap,
    output logic [WRAP_CW-1:0] o_wrap_cnt,
    output logic [ERR_CW-1:0]  o_err_cnt
);

    logic [WIDTH-1:0]   g_q;
    logic               s_vld_q;
    logic [WIDTH-1:0]   g_prev_q;
    logic [WIDTH-1:0]   b_prev_q;
    logic [WIDTH-1:0]   b_cur;
    logic [WIDTH-1:0]   b_inc;
    logic               bin_vld_q;
    logic               is_wrap;
    step_cls_e          cls;

    state_e             state_q, state_d;
    logic [RunW-1:0]    run_q, run_d;
    logic [ERR_CW-1:0]  err_cnt_q, err_cnt_d;
    logic [WRAP_CW-1:0] wrap_cnt_q, wrap_cnt_d;
    logic               step_err_q, step_err_d;
    logic               wrap_q, wrap_d;

    gray_step_monitor_gray2bin #(
        .WIDTH (WIDTH)
    ) u_gray2bin (
        .gray (g_q),
        .bin  (b_cur)
    );

    // Input capture; s_vld_q marks that g_q holds a real sample rather than the reset value.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            g_q     <= '0;
            s_vld_q <= 1'b0;
        end else begin
            g_q     <= i_gray;
            s_vld_q <= 1'b1;
        end
    end

    // Previous-sample registers; b_prev_q doubles as the o_bin output register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            g_prev_q  <= '0;
            b_prev_q  <= '0;
            bin_vld_q <= 1'b0;
        end else if (s_vld_q) begin
            g_prev_q  <= g_q;
            b_prev_q  <= b_cur;
            bin_vld_q <= 1'b1;
        end
    end

    // Classify current sample against the previous one (modular +1 in binary is a step).
    always_comb begin
        b_inc   = b_prev_q + WIDTH'(1);
        is_wrap = (b_prev_q == {WIDTH{1'b1}}) && (b_cur == '0);
        if (g_q == g_prev_q) begin
            cls = ClsHold;
        end else if (b_cur == b_inc) begin
            cls = ClsStep;
        end else begin
            cls = ClsBad;
        end
    end

    // Next-state logic for lock FSM, run/error/wrap counters and the 1-cycle pulses.
    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        err_cnt_d  = err_cnt_q;
        wrap_cnt_d = wrap_cnt_q;
        step_err_d = 1'b0;
        wrap_d     = 1'b0;
        if (s_vld_q) begin
            unique case (state_q)
                StAcq: begin
                    state_d = StHunt;
                end
                StHunt: begin
                    if (cls == ClsStep) begin
                        if (run_q == RunW'(LOCK_CNT - 1)) begin
                            state_d = StLocked;
                            run_d   = '0;
                        end else begin
                            run_d = run_q + RunW'(1);
                        end
                    end else if (cls == ClsBad) begin
                        run_d = '0;
                    end
                end
                StLocked: begin
                    if (cls == ClsBad) begin
                        state_d    = StHunt;
                        run_d      = '0;
                        step_err_d = 1'b1;
                        if (err_cnt_q != {ERR_CW{1'b1}}) begin
                            err_cnt_d = err_cnt_q + ERR_CW'(1);
                        end
                    end else if ((cls == ClsStep) && is_wrap) begin
                        wrap_d     = 1'b1;
                        wrap_cnt_d = wrap_cnt_q + WRAP_CW'(1);
                    end
                end
                default: begin
                    state_d = StAcq;
                    run_d   = '0;
                end
            endcase
        end
    end

    // State, counter and pulse registers; all update on the same edge as o_bin.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= StAcq;
            run_q      <= '0;
            err_cnt_q  <= '0;
            wrap_cnt_q <= '0;
            step_err_q <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            err_cnt_q  <= err_cnt_d;
            wrap_cnt_q <= wrap_cnt_d;
            step_err_q <= step_err_d;
            wrap_q     <= wrap_d;
        end
    end

    assign o_bin      = b_prev_q;
    assign o_bin_vld  = bin_vld_q;
    assign o_locked   = (state_q == StLocked);
    assign o_step_err = step_err_q;
    assign o_wrap     = wrap_q;
    assign o_wrap_cnt = wrap_cnt_q;
    assign o_err_cnt  = err_cnt_q;

endmodule
